// File: rtl/util_mw_clkchk.sv
// -----------------------------------------------------------------------------
// util_mw_clkchk
//
// Frequency checker for a clock living in another domain. The monitored domain
// flips tgl_in once per clock edge; this block synchronises that toggle into
// clk, counts its edges over a fixed window of GATE_CYCLES clk cycles and
// classifies the count against EXPECTED_COUNT +/- TOLERANCE (inclusive).
// While enable is high, windows run back-to-back with only the one-cycle EVAL
// state between them.
//
// Optional feature (macro UTIL_MW_CLKCHK_LOST_DETECT_EN): a watchdog that
// raises clk_lost after LOST_CYCLES edge-free clk cycles while enabled. With
// the macro undefined, clk_lost is tied low and no watchdog logic exists.
//
// Ports
//   clk          in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   enable       in   level; high runs measurement windows
//   tgl_in       in   asynchronous toggle from the monitored domain
//   meas_count   out  edge count of the last completed window
//   meas_valid   out  one-cycle pulse when the result outputs update
//   freq_ok      out  last window within tolerance
//   freq_err_lo  out  last window below EXPECTED_COUNT-TOLERANCE
//   freq_err_hi  out  last window above EXPECTED_COUNT+TOLERANCE
//   clk_lost     out  no tgl_in edge for LOST_CYCLES cycles
// -----------------------------------------------------------------------------
module util_mw_clkchk #(
  parameter int unsigned GATE_CYCLES    = 1000,
  parameter int unsigned EXPECTED_COUNT = 500,
  parameter int unsigned TOLERANCE      = 5,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned LOST_CYCLES    = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 tgl_in,
  output logic [CNT_WIDTH-1:0] meas_count,
  output logic                 meas_valid,
  output logic                 freq_ok,
  output logic                 freq_err_lo,
  output logic                 freq_err_hi,
  output logic                 clk_lost
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    EVAL = 2'd2
  } state_t;

  // Bounds are one bit wider than the counter so EXPECTED_COUNT+TOLERANCE
  // cannot wrap; a negative lower bound clamps to zero.
  localparam logic [CNT_WIDTH:0] LO_BOUND =
    (EXPECTED_COUNT > TOLERANCE) ? (CNT_WIDTH+1)'(EXPECTED_COUNT - TOLERANCE) : '0;
  localparam logic [CNT_WIDTH:0] HI_BOUND =
    (CNT_WIDTH+1)'(EXPECTED_COUNT) + (CNT_WIDTH+1)'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] GATE_LAST = CNT_WIDTH'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state_q;
  state_t               state_d;
  logic                 tgl_s1;
  logic                 tgl_s2;
  logic                 tgl_hist;
  logic                 tgl_edge;
  logic [CNT_WIDTH-1:0] gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic [CNT_WIDTH:0]   cnt_ext;
  logic                 gate_done;
  logic                 window_start;
  logic                 res_lo;
  logic                 res_hi;

  // Two-flop synchroniser plus a history flop; any change of the synchronised
  // level is one monitored-clock edge, regardless of polarity.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tgl_s1   <= 1'b0;
      tgl_s2   <= 1'b0;
      tgl_hist <= 1'b0;
    end else begin
      tgl_s1   <= tgl_in;
      tgl_s2   <= tgl_s1;
      tgl_hist <= tgl_s2;
    end
  end

  assign tgl_edge = tgl_s2 ^ tgl_hist;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign gate_done = (gate_cnt == GATE_LAST);

  // NOTE: next state takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = GATE;
      GATE: begin
        // Dropping enable abandons the window, even on its final cycle.
        if (!enable)        state_d = IDLE;
        else if (gate_done) state_d = EVAL;
      end
      EVAL:    state_d = enable ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters clear on the cycle that enters GATE so each window starts fresh.
  assign window_start = (state_d == GATE) && (state_q != GATE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (window_start) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (state_q == GATE) begin
      gate_cnt <= gate_cnt + CNT_ONE;
      // Saturate rather than wrap so a runaway input still reads as "high".
      if (tgl_edge && (edge_cnt != '1)) edge_cnt <= edge_cnt + CNT_ONE;
    end
  end

  assign cnt_ext = {1'b0, edge_cnt};
  assign res_lo  = (cnt_ext < LO_BOUND);
  assign res_hi  = (cnt_ext > HI_BOUND);

  // Results are registered in EVAL, so they appear one cycle later together
  // with meas_valid and then hold until the next completed window.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meas_count  <= '0;
      meas_valid  <= 1'b0;
      freq_ok     <= 1'b0;
      freq_err_lo <= 1'b0;
      freq_err_hi <= 1'b0;
    end else begin
      meas_valid <= (state_q == EVAL);
      if (state_q == EVAL) begin
        meas_count  <= edge_cnt;
        freq_err_lo <= res_lo;
        freq_err_hi <= res_hi;
        freq_ok     <= !res_lo && !res_hi;
      end
    end
  end

`ifdef UTIL_MW_CLKCHK_LOST_DETECT_EN
  localparam logic [CNT_WIDTH-1:0] LOST_LIMIT = CNT_WIDTH'(LOST_CYCLES);

  logic [CNT_WIDTH-1:0] lost_cnt;

  // Counts edge-free cycles while enabled and parks at the limit, so clk_lost
  // stays up until the next synchronised edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lost_cnt <= '0;
    end else if (!enable || tgl_edge) begin
      lost_cnt <= '0;
    end else if (lost_cnt != LOST_LIMIT) begin
      lost_cnt <= lost_cnt + CNT_ONE;
    end
  end

  assign clk_lost = (lost_cnt == LOST_LIMIT);
`else
  assign clk_lost = 1'b0;
`endif

endmodule

// File: tb/tb_util_mw_clkchk.sv
// -----------------------------------------------------------------------------
// tb_util_mw_clkchk
//
// Directed bench for util_mw_clkchk at default parameters. Expected window
// results are queued when a window is started and compared when meas_valid
// pulses, including the exact cycle of the pulse. Inputs are driven on the
// falling edge; cyc counts rising edges.
// -----------------------------------------------------------------------------
module tb_util_mw_clkchk;

`ifdef UTIL_MW_CLKCHK_LOST_DETECT_EN
  localparam logic LOST_EN = 1'b1;
`else
  localparam logic LOST_EN = 1'b0;
`endif
  localparam int INT_MAX = 32'h7fff_ffff;

  typedef struct {
    int unsigned count;
    logic        ok;
    logic        lo;
    logic        hi;
    int          at_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        tgl_in;
  logic [31:0] meas_count;
  logic        meas_valid;
  logic        freq_ok;
  logic        freq_err_lo;
  logic        freq_err_hi;
  logic        clk_lost;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Toggle generator state: mode 0 = quiet, 1 = periodic, 2 = scheduled.
  int mode;
  int period;
  int phase;
  int stop_at;
  int t_last;
  int g0;
  int sched_n[4] = '{506, 505, 495, 494};
  int base;
  int t_r;

  util_mw_clkchk dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .tgl_in      (tgl_in),
    .meas_count  (meas_count),
    .meas_valid  (meas_valid),
    .freq_ok     (freq_ok),
    .freq_err_lo (freq_err_lo),
    .freq_err_hi (freq_err_hi),
    .clk_lost    (clk_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_result(input int unsigned c, input logic ok, input logic lo,
                               input logic hi, input int at_cyc);
    exp_t e;
    e.count  = c;
    e.ok     = ok;
    e.lo     = lo;
    e.hi     = hi;
    e.at_cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  // One clock: wait for the falling edge, then drive the next tgl_in value.
  // A flip driven at cyc=t is counted as an edge during cycle t+2.
  task automatic tick();
    int d;
    int r;
    int w;
    int n;
    @(negedge clk);
    if (mode == 1) begin
      if (cyc <= stop_at) begin
        phase++;
        if (phase >= period) begin
          phase  = 0;
          tgl_in = ~tgl_in;
          t_last = cyc;
        end
      end
    end else if (mode == 2) begin
      d = cyc + 2 - g0;
      if (d >= 0) begin
        w = d / 1001;
        r = d % 1001;
        if (w < 4) begin
          n = sched_n[w];
          if (n > 495) begin
            if (r >= 10 && r < 10 + n) tgl_in = ~tgl_in;
          end else if (r >= 10 && r < 10 + 2 * n && ((r - 10) % 2) == 0) begin
            tgl_in = ~tgl_in;
          end
        end
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Scoreboard: every meas_valid pulse must match the oldest queued window.
  always @(negedge clk) begin
    if (resetn && meas_valid) begin
      check("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("valid_cycle", 64'(cyc), 64'(mon_e.at_cyc));
        check("meas_count", 64'(meas_count), 64'(mon_e.count));
        check("freq_ok", 64'(freq_ok), 64'(mon_e.ok));
        check("freq_err_lo", 64'(freq_err_lo), 64'(mon_e.lo));
        check("freq_err_hi", 64'(freq_err_hi), 64'(mon_e.hi));
      end
    end
  end

  initial begin
    resetn  = 1'b0;
    enable  = 1'b0;
    tgl_in  = 1'b0;
    mode    = 0;
    period  = 2;
    phase   = 0;
    stop_at = INT_MAX;
    t_last  = 0;
    g0      = 0;

    // Reset values.
    repeat (4) tick();
    check("rst_meas_count", 64'(meas_count), 64'd0);
    check("rst_meas_valid", 64'(meas_valid), 64'd0);
    check("rst_freq_ok", 64'(freq_ok), 64'd0);
    check("rst_freq_err_lo", 64'(freq_err_lo), 64'd0);
    check("rst_freq_err_hi", 64'(freq_err_hi), 64'd0);
    check("rst_clk_lost", 64'(clk_lost), 64'd0);
    resetn = 1'b1;

    // Nominal rate, two back-to-back windows: 500 edges each, pulse at
    // GATE entry + 1001 and then every 1001 cycles.
    mode = 1; period = 2; phase = 0;
    repeat (20) tick();
    enable = 1'b1;
    base = cyc;
    expect_result(500, 1'b1, 1'b0, 1'b0, base + 1002);
    expect_result(500, 1'b1, 1'b0, 1'b0, base + 2003);
    run_to(base + 2003);
    enable = 1'b0;
    repeat (5) tick();
    check("drain_nominal", 64'(exp_q.size()), 64'd0);

    // Half rate: 250 edges, below tolerance.
    period = 4; phase = 0;
    repeat (20) tick();
    enable = 1'b1;
    base = cyc;
    expect_result(250, 1'b0, 1'b1, 1'b0, base + 1002);
    run_to(base + 1002);
    enable = 1'b0;
    repeat (5) tick();
    check("drain_slow", 64'(exp_q.size()), 64'd0);

    // Tolerance boundaries, four back-to-back windows: 506, 505, 495, 494.
    mode = 0;
    repeat (10) tick();
    enable = 1'b1;
    base = cyc;
    g0 = base + 1;
    mode = 2;
    expect_result(506, 1'b0, 1'b0, 1'b1, base + 1002);
    expect_result(505, 1'b1, 1'b0, 1'b0, base + 2003);
    expect_result(495, 1'b1, 1'b0, 1'b0, base + 3004);
    expect_result(494, 1'b0, 1'b1, 1'b0, base + 4005);
    run_to(base + 4005);
    enable = 1'b0;
    mode = 0;
    repeat (5) tick();
    check("drain_bounds", 64'(exp_q.size()), 64'd0);

    // Abort at GATE cycle 300: no pulse, previous result (494, low) holds.
    mode = 1; period = 2; phase = 0;
    repeat (20) tick();
    enable = 1'b1;
    base = cyc;
    run_to(base + 1 + 300);
    enable = 1'b0;
    repeat (20) tick();
    check("hold_meas_count", 64'(meas_count), 64'd494);
    check("hold_freq_ok", 64'(freq_ok), 64'd0);
    check("hold_freq_err_lo", 64'(freq_err_lo), 64'd1);
    check("hold_freq_err_hi", 64'(freq_err_hi), 64'd0);
    check("drain_abort", 64'(exp_q.size()), 64'd0);
    enable = 1'b1;
    base = cyc;
    expect_result(500, 1'b1, 1'b0, 1'b0, base + 1002);
    run_to(base + 1002);
    enable = 1'b0;
    repeat (5) tick();
    check("drain_reenable", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-GATE, then a full fresh window.
    enable = 1'b1;
    base = cyc;
    run_to(base + 400);
    #2 resetn = 1'b0;
    #1;
    check("async_meas_count", 64'(meas_count), 64'd0);
    check("async_meas_valid", 64'(meas_valid), 64'd0);
    check("async_freq_ok", 64'(freq_ok), 64'd0);
    check("async_freq_err_lo", 64'(freq_err_lo), 64'd0);
    check("async_freq_err_hi", 64'(freq_err_hi), 64'd0);
    check("async_clk_lost", 64'(clk_lost), 64'd0);
    enable = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (10) tick();
    enable = 1'b1;
    base = cyc;
    expect_result(500, 1'b1, 1'b0, 1'b0, base + 1002);
    run_to(base + 1002);
    enable = 1'b0;
    repeat (5) tick();
    check("drain_reset", 64'(exp_q.size()), 64'd0);

    // Input freezes at the end of a window: next window reads 0 (low) and
    // the watchdog fires 64 edge-free cycles after the last counted edge.
    repeat (10) tick();
    enable = 1'b1;
    base = cyc;
    stop_at = base + 1 + 997;
    expect_result(500, 1'b1, 1'b0, 1'b0, base + 1002);
    expect_result(0, 1'b0, 1'b1, 1'b0, base + 2003);
    run_to(base + 999);
    run_to(t_last + 66);
    check("lost_before_limit", 64'(clk_lost), 64'd0);
    tick();
    check("lost_at_limit", 64'(clk_lost), 64'(LOST_EN));
    run_to(base + 2003);
    repeat (5) tick();
    tgl_in = ~tgl_in;
    t_r = cyc;
    mode = 0;
    stop_at = INT_MAX;
    run_to(t_r + 2);
    check("lost_until_edge", 64'(clk_lost), 64'(LOST_EN));
    tick();
    check("lost_cleared", 64'(clk_lost), 64'd0);
    enable = 1'b0;
    repeat (5) tick();
    check("drain_lost", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
